// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_pipe
// Brief    : 3-stage pipelined floating-point multiplier with valid/ready
//            handshakes, flush-to-zero and five rounding modes.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+FRC_W:0] fp_X,
    input  logic [EXP_W+FRC_W:0] fp_Y,
    input  logic [2:0]           r_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+FRC_W:0] fp_Z,
    output logic                 ovrf,
    output logic                 udrf,
    output logic                 zer,
    output logic                 inf,
    output logic                 nan
);
    localparam int c_PW = 2*FRC_W + 2;
    localparam int c_EW = EXP_W + 2;
    localparam logic [c_EW-1:0] c_BIAS = c_EW'((1 << (EXP_W-1)) - 1);
    localparam logic [c_EW-1:0] c_ONE  = c_EW'(1);
    localparam logic [c_EW-1:0] c_EMAX = c_EW'((1 << EXP_W) - 1);
    localparam logic [2:0] c_RTZ = 3'b001;
    localparam logic [2:0] c_RDN = 3'b010;
    localparam logic [2:0] c_RUP = 3'b011;
    localparam logic [2:0] c_RMM = 3'b100;

    // Stall chain: each stage may load when empty or when its successor moves.
    logic r_v1, r_v2, r_v3;
    logic w_en1, w_en2, w_en3;
    assign w_en3    = !r_v3 || out_ready;
    assign w_en2    = !r_v2 || w_en3;
    assign w_en1    = !r_v1 || w_en2;
    assign in_ready = w_en1;

    // ---------------- S1: unpack / multiply ----------------
    logic [EXP_W-1:0] w_ex, w_ey;
    logic [FRC_W-1:0] w_fx, w_fy;
    logic             w_zx, w_zy, w_ix, w_iy, w_nx, w_ny;
    logic [c_PW-1:0]  w_mx, w_my, w_prod;
    logic [c_EW-1:0]  w_esum;

    assign w_ex   = fp_X[FRC_W +: EXP_W];
    assign w_ey   = fp_Y[FRC_W +: EXP_W];
    assign w_fx   = fp_X[FRC_W-1:0];
    assign w_fy   = fp_Y[FRC_W-1:0];
    assign w_zx   = (w_ex == '0);
    assign w_zy   = (w_ey == '0);
    assign w_ix   = (w_ex == '1) && (w_fx == '0);
    assign w_iy   = (w_ey == '1) && (w_fy == '0);
    assign w_nx   = (w_ex == '1) && (w_fx != '0);
    assign w_ny   = (w_ey == '1) && (w_fy != '0);
    assign w_mx   = {{(FRC_W+1){1'b0}}, 1'b1, w_fx};
    assign w_my   = {{(FRC_W+1){1'b0}}, 1'b1, w_fy};
    assign w_prod = w_mx * w_my;
    assign w_esum = {2'b00, w_ex} + {2'b00, w_ey} - c_BIAS;

    logic            r_s1_sign, r_s1_nan, r_s1_inf, r_s1_zero;
    logic [2:0]      r_s1_mode;
    logic [c_PW-1:0] r_s1_prod;
    logic [c_EW-1:0] r_s1_esum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_nan  <= 1'b0;
            r_s1_inf  <= 1'b0;
            r_s1_zero <= 1'b0;
            r_s1_mode <= '0;
            r_s1_prod <= '0;
            r_s1_esum <= '0;
        end else if (w_en1) begin
            r_v1      <= in_valid;
            r_s1_sign <= fp_X[EXP_W+FRC_W] ^ fp_Y[EXP_W+FRC_W];
            r_s1_nan  <= w_nx || w_ny || (w_ix && w_zy) || (w_iy && w_zx);
            r_s1_inf  <= w_ix || w_iy;
            r_s1_zero <= w_zx || w_zy;
            r_s1_mode <= r_mode;
            r_s1_prod <= w_prod;
            r_s1_esum <= w_esum;
        end
    end

    // ---------------- S2: normalise / round ----------------
    logic [FRC_W:0]   w_sig;
    logic             w_g, w_st, w_inc;
    logic [FRC_W+1:0] w_rnd;
    logic [c_EW-1:0]  w_exp_n, w_exp_r;
    logic [FRC_W-1:0] w_frac_r;

    always_comb begin
        w_sig   = '0;
        w_g     = 1'b0;
        w_st    = 1'b0;
        w_exp_n = r_s1_esum;
        if (r_s1_prod[c_PW-1]) begin
            w_sig   = r_s1_prod[c_PW-1 -: FRC_W+1];
            w_g     = r_s1_prod[FRC_W];
            w_st    = |r_s1_prod[FRC_W-1:0];
            w_exp_n = r_s1_esum + c_ONE;
        end else begin
            w_sig   = r_s1_prod[c_PW-2 -: FRC_W+1];
            w_g     = r_s1_prod[FRC_W-1];
            w_st    = |r_s1_prod[FRC_W-2:0];
        end

        w_inc = 1'b0;
        case (r_s1_mode)
            c_RTZ:   w_inc = 1'b0;
            c_RDN:   w_inc = r_s1_sign && (w_g || w_st);
            c_RUP:   w_inc = !r_s1_sign && (w_g || w_st);
            c_RMM:   w_inc = w_g;
            default: w_inc = w_g && (w_st || w_sig[0]);
        endcase

        w_rnd = {1'b0, w_sig} + {{(FRC_W+1){1'b0}}, w_inc};
        // Carry out of the rounding add means the significand became 10.000...
        if (w_rnd[FRC_W+1]) begin
            w_exp_r  = w_exp_n + c_ONE;
            w_frac_r = '0;
        end else begin
            w_exp_r  = w_exp_n;
            w_frac_r = w_rnd[FRC_W-1:0];
        end
    end

    logic             r_s2_sign, r_s2_nan, r_s2_inf, r_s2_zero;
    logic [2:0]       r_s2_mode;
    logic [c_EW-1:0]  r_s2_exp;
    logic [FRC_W-1:0] r_s2_frac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2      <= 1'b0;
            r_s2_sign <= 1'b0;
            r_s2_nan  <= 1'b0;
            r_s2_inf  <= 1'b0;
            r_s2_zero <= 1'b0;
            r_s2_mode <= '0;
            r_s2_exp  <= '0;
            r_s2_frac <= '0;
        end else if (w_en2) begin
            r_v2      <= r_v1;
            r_s2_sign <= r_s1_sign;
            r_s2_nan  <= r_s1_nan;
            r_s2_inf  <= r_s1_inf;
            r_s2_zero <= r_s1_zero;
            r_s2_mode <= r_s1_mode;
            r_s2_exp  <= w_exp_r;
            r_s2_frac <= w_frac_r;
        end
    end

    // ---------------- S3: exceptions / pack ----------------
    logic [EXP_W+FRC_W:0] w_z;
    logic                 w_ovrf, w_udrf, w_zer, w_inf, w_nan;
    logic                 w_uf, w_of, w_to_inf;

    assign w_uf     = r_s2_exp[c_EW-1] || (r_s2_exp == '0);
    assign w_of     = !r_s2_exp[c_EW-1] && (r_s2_exp >= c_EMAX);
    assign w_to_inf = !((r_s2_mode == c_RTZ) ||
                        (r_s2_mode == c_RDN && !r_s2_sign) ||
                        (r_s2_mode == c_RUP && r_s2_sign));

    always_comb begin
        w_z    = '0;
        w_ovrf = 1'b0;
        w_udrf = 1'b0;
        w_zer  = 1'b0;
        w_inf  = 1'b0;
        w_nan  = 1'b0;
        if (r_s2_nan) begin
            w_z   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRC_W-1){1'b0}}};
            w_nan = 1'b1;
        end else if (r_s2_inf) begin
            w_z   = {r_s2_sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
            w_inf = 1'b1;
        end else if (r_s2_zero) begin
            w_z   = {r_s2_sign, {(EXP_W+FRC_W){1'b0}}};
            w_zer = 1'b1;
        end else if (w_uf) begin
            w_z    = {r_s2_sign, {(EXP_W+FRC_W){1'b0}}};
            w_udrf = 1'b1;
            w_zer  = 1'b1;
        end else if (w_of) begin
            w_ovrf = 1'b1;
            if (w_to_inf) begin
                w_z   = {r_s2_sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
                w_inf = 1'b1;
            end else begin
                w_z = {r_s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
            end
        end else begin
            w_z = {r_s2_sign, r_s2_exp[EXP_W-1:0], r_s2_frac};
        end
    end

    logic [EXP_W+FRC_W:0] r_z;
    logic [4:0]           r_flags;

    // A bubble entering the output register clears it so idle outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3    <= 1'b0;
            r_z     <= '0;
            r_flags <= '0;
        end else if (w_en3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_z     <= w_z;
                r_flags <= {w_ovrf, w_udrf, w_zer, w_inf, w_nan};
            end else begin
                r_z     <= '0;
                r_flags <= '0;
            end
        end
    end

    assign out_valid = r_v3;
    assign fp_Z      = r_z;
    assign ovrf      = r_flags[4];
    assign udrf      = r_flags[3];
    assign zer       = r_flags[2];
    assign inf       = r_flags[1];
    assign nan       = r_flags[0];

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_pipe
// Brief    : Scoreboard bench for fp_mul_pipe (single-precision instance).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] fp_X = '0;
    logic [31:0] fp_Y = '0;
    logic [2:0]  r_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] fp_Z;
    logic        ovrf, udrf, zer, inf, nan;
    logic [36:0] w_act;

    fp_mul_pipe #(.EXP_W(8), .FRC_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode), .out_valid(out_valid),
        .out_ready(out_ready), .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf),
        .zer(zer), .inf(inf), .nan(nan)
    );

    assign w_act = {fp_Z, ovrf, udrf, zer, inf, nan};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [36:0] exp;
        int          acc;
        bit          lat;
    } sb_t;
    sb_t sbq[$];

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    bit lat_mode = 1'b0;
    bit rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer product, rounded by remainder comparison.
    function automatic logic [36:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] m);
        int     ex, ey, e, sh;
        longint mx, my, p, q, rem, half;
        logic   s;
        bit     xz, yz, xi, yi, xn, yn, up, to_inf;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        if (xn || yn || (xi && yz) || (yi && xz)) return {32'h7FC00000, 5'b00001};
        if (xi || yi) return {s, 8'hFF, 23'h0, 5'b00010};
        if (xz || yz) return {s, 31'h0, 5'b00100};
        mx = longint'(x[22:0]) + (longint'(1) << 23);
        my = longint'(y[22:0]) + (longint'(1) << 23);
        p  = mx * my;
        e  = ex + ey - 127;
        sh = 23;
        if (p >= (longint'(1) << 47)) begin
            sh = 24;
            e++;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        case (m)
            3'd1:    up = 1'b0;
            3'd2:    up = s && (rem != 0);
            3'd3:    up = !s && (rem != 0);
            3'd4:    up = (rem >= half);
            default: up = (rem > half) || ((rem == half) && q[0]);
        endcase
        q = q + longint'(up);
        if (q == (longint'(1) << 24)) begin
            q = longint'(1) << 23;
            e++;
        end
        if (e <= 0) return {s, 31'h0, 5'b01100};
        if (e >= 255) begin
            case (m)
                3'd1:    to_inf = 1'b0;
                3'd2:    to_inf = s;
                3'd3:    to_inf = !s;
                default: to_inf = 1'b1;
            endcase
            if (to_inf) return {s, 8'hFF, 23'h0, 5'b10010};
            return {s, 8'hFE, 23'h7FFFFF, 5'b10000};
        end
        return {s, 8'(e), q[22:0], 5'b00000};
    endfunction

    // Caller is positioned just after a rising edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                        input logic [36:0] exp);
        int t = 0;
        fp_X     = x;
        fp_Y     = y;
        r_mode   = m;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back('{exp, cyc, lat_mode});
                n_acc++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            t++;
            if (t > 500) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 within 500 cycles");
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic sendm(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        send(x, y, m, ref_mul(x, y, m));
    endtask

    task automatic drain();
        int t = 0;
        while ((sbq.size() != 0 || out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 64'(sbq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_op();
        logic [7:0] e;
        int         k;
        logic [22:0] f;
        k = int'($urandom_range(15));
        f = 23'($urandom());
        if (k == 0) e = 8'h00;
        else if (k == 1) begin
            e = 8'hFF;
            if ($urandom_range(1) == 0) f = '0;
        end
        else if (k < 6) e = 8'($urandom_range(254, 1));
        else e = 8'($urandom_range(160, 96));
        return {1'($urandom_range(1)), e, f};
    endfunction

    // Monitor: retire outputs against the scoreboard and check hold stability.
    bit          hold = 1'b0;
    logic [36:0] held = '0;
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold) chk("hold_stable", {27'h0, out_valid, w_act}, {27'h0, 1'b1, held});
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected no output", w_act);
                end else begin
                    e = sbq.pop_front();
                    chk("result", 64'(w_act), 64'(e.exp));
                    if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd3);
                end
            end
            hold = out_valid && !out_ready;
            held = w_act;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {27'h0, out_valid, w_act}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        lat_mode = 1'b1;
        send(32'h40400000, 32'h40400000, 3'd1, {32'h41100000, 5'b00000});
        send(32'h3F800001, 32'h3F800001, 3'd0, {32'h3F800002, 5'b00000});
        send(32'h3F800001, 32'h3F800001, 3'd1, {32'h3F800002, 5'b00000});
        send(32'h3F800001, 32'h3F800001, 3'd2, {32'h3F800002, 5'b00000});
        send(32'h3F800001, 32'h3F800001, 3'd3, {32'h3F800003, 5'b00000});
        send(32'h3F800001, 32'h3F800001, 3'd4, {32'h3F800002, 5'b00000});
        send(32'h7F000000, 32'h40000000, 3'd0, {32'h7F800000, 5'b10010});
        send(32'h7F000000, 32'h40000000, 3'd1, {32'h7F7FFFFF, 5'b10000});
        send(32'hFF000000, 32'h40000000, 3'd3, {32'hFF7FFFFF, 5'b10000});
        send(32'hFF000000, 32'h40000000, 3'd2, {32'hFF800000, 5'b10010});
        send(32'h7F800000, 32'h00000000, 3'd0, {32'h7FC00000, 5'b00001});
        send(32'h7F800000, 32'h3F800000, 3'd0, {32'h7F800000, 5'b00010});
        send(32'h00400000, 32'h40000000, 3'd0, {32'h00000000, 5'b00100});
        send(32'h20000000, 32'h1F800000, 3'd0, {32'h00000000, 5'b01100});
        send(32'hC0400000, 32'h40400000, 3'd7, {32'hC1100000, 5'b00000});
        drain();

        lat_mode  = 1'b0;
        out_ready = 1'b0;
        base      = n_acc;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    sendm(32'h3F800000 + 32'(i * 32'h00123457), 32'h40200000 - 32'(i * 32'h8001), 3'(i));
            end
            begin
                repeat (8) @(negedge clk);
                chk("bp_accepted", 64'(n_acc - base), 64'd3);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) sendm(32'h41000000 + 32'(i), 32'h3FC00000, 3'd0);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_flush", {27'h0, out_valid, w_act}, 64'd0);
        sbq.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_stale_output", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        lat_mode = 1'b1;
        send(32'h40400000, 32'h40400000, 3'd1, {32'h41100000, 5'b00000});
        drain();

        lat_mode = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) begin
                @(posedge clk);
                #1;
            end
            sendm(rnd_op(), rnd_op(), 3'($urandom_range(7)));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
